// File: rtl/store_forward_buffer.sv
// Small fully-associative store buffer in the MEM stage: keeps recent word stores
// and forwards their data to later loads that hit the same word address.
module store_forward_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic        INVALIDATE_IN,
  input  logic        MemRead_IN,
  input  logic        MemWrite_IN,
  input  logic [31:0] Address_IN,
  input  logic [31:0] StoreData_IN,
  output logic [31:0] FWriteData_OUT,
  output logic        forward_OUT,
  output logic [4:0]  Count_OUT
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DEPTH-1:0] valid;
  logic [29:0]      tag  [DEPTH];
  logic [31:0]      data [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic [DEPTH-1:0] match_vec;
  logic             tag_match;
  logic [31:0]      match_data;
  logic             hit;
  logic             update;
  logic             addr_lsb_unused;

  // Byte offset within the word never takes part in the tag compare.
  assign addr_lsb_unused = ^Address_IN[1:0];

  // Tags are unique among valid entries, so an OR-reduction of the
  // masked entry data yields the single matching word.
  always_comb begin
    match_vec  = '0;
    match_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = valid[i] && (tag[i] == Address_IN[31:2]);
      if (match_vec[i]) match_data = match_data | data[i];
    end
    tag_match = |match_vec;
  end

  assign hit            = MemRead_IN && tag_match;
  assign forward_OUT    = hit && !FLUSH;
  assign FWriteData_OUT = hit ? match_data : 32'h0;
  assign Count_OUT      = 5'(count);

  assign update = MemWrite_IN && !STALL && !FLUSH && !INVALIDATE_IN;

  // Control state: valid bits, write pointer and occupancy.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      valid  <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (INVALIDATE_IN) begin
      valid  <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (update && !tag_match) begin
      valid[wr_ptr] <= 1'b1;
      wr_ptr        <= wr_ptr + PTR_W'(1);
      if (count != FULL) count <= count + CNT_W'(1);
    end
  end

  // Entry payload: a matching store rewrites its entry in place, a new tag
  // takes the slot at wr_ptr, which is the oldest entry once the buffer is full.
  always_ff @(posedge CLOCK) begin
    if (RESET && update) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (tag_match) begin
          if (match_vec[i]) data[i] <= StoreData_IN;
        end else if (wr_ptr == PTR_W'(i)) begin
          tag[i]  <= Address_IN[31:2];
          data[i] <= StoreData_IN;
        end
      end
    end
  end

endmodule

// File: tb/tb_store_forward_buffer.sv
// Directed bench for store_forward_buffer: stimulus pushes expected lookup
// results into a queue, a negedge monitor pops and compares them.
module tb_store_forward_buffer;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        STALL = 1'b0;
  logic        FLUSH = 1'b0;
  logic        INVALIDATE_IN = 1'b0;
  logic        MemRead_IN = 1'b0;
  logic        MemWrite_IN = 1'b0;
  logic [31:0] Address_IN = '0;
  logic [31:0] StoreData_IN = '0;
  logic [31:0] FWriteData_OUT;
  logic        forward_OUT;
  logic [4:0]  Count_OUT;

  store_forward_buffer #(.DEPTH(4)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
    .INVALIDATE_IN(INVALIDATE_IN), .MemRead_IN(MemRead_IN), .MemWrite_IN(MemWrite_IN),
    .Address_IN(Address_IN), .StoreData_IN(StoreData_IN),
    .FWriteData_OUT(FWriteData_OUT), .forward_OUT(forward_OUT), .Count_OUT(Count_OUT)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic        fwd;
    logic [31:0] dat;
    logic [4:0]  cnt;
    string       nm;
  } exp_t;

  exp_t q[$];
  bit   chk_req = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: the DUT presents a lookup result every cycle; sample the ones
  // the stimulus asked for, mid-cycle.
  always @(negedge CLOCK) begin
    if (chk_req) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL %s: no expected entry queued", "scoreboard");
      end else begin
        exp_t e;
        e = q.pop_front();
        n_cmp++;
        if (forward_OUT !== e.fwd) begin
          n_bad++;
          $display("FAIL %s.fwd: got %b want %b", e.nm, forward_OUT, e.fwd);
        end
        n_cmp++;
        if (FWriteData_OUT !== e.dat) begin
          n_bad++;
          $display("FAIL %s.data: got %h want %h", e.nm, FWriteData_OUT, e.dat);
        end
        n_cmp++;
        if (Count_OUT !== e.cnt) begin
          n_bad++;
          $display("FAIL %s.count: got %0d want %0d", e.nm, Count_OUT, e.cnt);
        end
      end
    end
  end

  task automatic cyc(input logic rst_n, input logic rd, input logic wr, input logic stl,
                     input logic fls, input logic inv, input logic [31:0] a, input logic [31:0] d);
    @(posedge CLOCK); #1;
    RESET = rst_n; MemRead_IN = rd; MemWrite_IN = wr; STALL = stl; FLUSH = fls;
    INVALIDATE_IN = inv; Address_IN = a; StoreData_IN = d; chk_req = 1'b0;
  endtask

  task automatic expect_now(input logic f, input logic [31:0] dt, input logic [4:0] c, input string nm);
    exp_t e;
    e.fwd = f; e.dat = dt; e.cnt = c; e.nm = nm;
    q.push_back(e);
    chk_req = 1'b1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    cyc(1, 0, 1, 0, 0, 0, a, d);
  endtask

  task automatic load(input logic [31:0] a);
    cyc(1, 1, 0, 0, 0, 0, a, 32'h0);
  endtask

  task automatic inval();
    cyc(1, 0, 0, 0, 0, 1, 32'h0, 32'h0);
  endtask

  initial begin
    int wait_cyc;
    // Reset
    cyc(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    cyc(0, 1, 1, 1, 1, 1, 32'h1000, 32'hFFFF_FFFF); expect_now(0, 32'h0, 5'd0, "reset_state");

    // Basic store then forward
    store(32'h1000, 32'hDEAD_BEEF);                 expect_now(0, 32'h0, 5'd0, "st_1000");
    load(32'h1000);                                 expect_now(1, 32'hDEAD_BEEF, 5'd1, "ld_1000");

    // Overwrite in place; byte offset ignored
    inval();
    store(32'h2000, 32'h11);
    store(32'h2000, 32'h22);                        expect_now(0, 32'h0, 5'd1, "st_2000_again");
    load(32'h2002);                                 expect_now(1, 32'h22, 5'd1, "ld_2002");

    // Fill past DEPTH: oldest replaced
    inval();
    store(32'h00, 32'h00);
    store(32'h04, 32'h04);
    store(32'h08, 32'h08);
    store(32'h0C, 32'h0C);                          expect_now(0, 32'h0, 5'd3, "fill_cnt3");
    store(32'h10, 32'h10);                          expect_now(0, 32'h0, 5'd4, "fill_cnt4");
    load(32'h00);                                   expect_now(0, 32'h0, 5'd4, "ld_evicted_00");
    load(32'h10);                                   expect_now(1, 32'h10, 5'd4, "ld_10");
    load(32'h04);                                   expect_now(1, 32'h04, 5'd4, "ld_04");
    // Read+write together: forward from pre-update state, then update
    cyc(1, 1, 1, 0, 0, 0, 32'h04, 32'h44);          expect_now(1, 32'h04, 5'd4, "rdwr_04");
    load(32'h04);                                   expect_now(1, 32'h44, 5'd4, "ld_04_new");
    load(32'h08);                                   expect_now(1, 32'h08, 5'd4, "ld_08_kept");

    // Stall / flush block updates; lookups still driven
    inval();
    cyc(1, 0, 1, 1, 0, 0, 32'h3000, 32'h33);        expect_now(0, 32'h0, 5'd0, "st_stall");
    cyc(1, 0, 1, 0, 1, 0, 32'h3000, 32'h33);        expect_now(0, 32'h0, 5'd0, "st_flush");
    load(32'h3000);                                 expect_now(0, 32'h0, 5'd0, "ld_3000_miss");
    store(32'h3000, 32'h33);
    cyc(1, 1, 0, 0, 1, 0, 32'h3000, 32'h0);         expect_now(0, 32'h33, 5'd1, "ld_hit_flush");
    cyc(1, 1, 0, 1, 0, 0, 32'h3000, 32'h0);         expect_now(1, 32'h33, 5'd1, "ld_hit_stall");

    // Invalidate overrides concurrent store
    inval();
    store(32'h100, 32'hA0);
    store(32'h104, 32'hA4);
    store(32'h108, 32'hA8);
    cyc(1, 0, 1, 0, 0, 1, 32'h4000, 32'h44);        expect_now(0, 32'h0, 5'd3, "inv_with_st");
    load(32'h4000);                                 expect_now(0, 32'h0, 5'd0, "ld_4000_miss");
    load(32'h100);                                  expect_now(0, 32'h0, 5'd0, "ld_100_miss");
    load(32'h108);                                  expect_now(0, 32'h0, 5'd0, "ld_108_miss");

    // Mid-operation reset, then refill shows wr_ptr restarted at entry 0
    store(32'h500, 32'h50);
    store(32'h504, 32'h54);
    cyc(0, 0, 1, 0, 0, 0, 32'h508, 32'h58);         expect_now(0, 32'h0, 5'd2, "rst_with_st");
    load(32'h500);                                  expect_now(0, 32'h0, 5'd0, "ld_after_rst");
    store(32'h700, 32'h70);
    store(32'h704, 32'h74);
    store(32'h708, 32'h78);
    store(32'h70C, 32'h7C);
    store(32'h710, 32'h71);
    load(32'h700);                                  expect_now(0, 32'h0, 5'd4, "ld_700_evicted");
    load(32'h704);                                  expect_now(1, 32'h74, 5'd4, "ld_704_kept");
    load(32'h710);                                  expect_now(1, 32'h71, 5'd4, "ld_710");

    cyc(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    wait_cyc = 0;
    while (q.size() != 0 && wait_cyc < 20) begin
      @(posedge CLOCK);
      wait_cyc++;
    end
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
